// File: rtl/fir_coeff_loader_pkg.sv
// fir_pkg -- shared FIR sizing constants and coefficient-loader state encoding.
// Revision: 1.0
`default_nettype none

package fir_pkg;

   localparam int FILTER_SIZE = 204;
   localparam int COEFF_W     = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      DRAIN   = 2'd2,
      PENDING = 2'd3
   } fir_state_e;

endpackage

`default_nettype wire

// File: rtl/fir_coeff_loader_if.sv
// fir_coeff_loader_if -- valid/ready coefficient stream with end-of-set marker.
// Revision: 1.0
`default_nettype none

interface fir_coeff_loader_if #(
   parameter int COEFF_W = 16
);
   logic               s_valid;
   logic               s_ready;
   logic [COEFF_W-1:0] s_data;
   logic               s_last;

   modport master (output s_valid, output s_data, output s_last, input  s_ready);
   modport slave  (input  s_valid, input  s_data, input  s_last, output s_ready);
endinterface

`default_nettype wire

// File: rtl/fir_coeff_bank.sv
// fir_coeff_bank -- shadow bank with write port plus active bank loaded by a single-edge parallel copy.
// Revision: 1.0
`default_nettype none

module fir_coeff_bank #(
   parameter int FILTER_SIZE = 204,
   parameter int COEFF_W     = 16,
   parameter int IDX_W       = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1
) (
   input  wire logic                           clk,
   input  wire logic                           reset,
   input  wire logic                           i_wr_en,
   input  wire logic [IDX_W-1:0]               i_wr_addr,
   input  wire logic [COEFF_W-1:0]             i_wr_data,
   input  wire logic                           i_copy,
   output      logic [FILTER_SIZE*COEFF_W-1:0] o_active
);

   logic [FILTER_SIZE-1:0][COEFF_W-1:0] r_shadow;
   logic [FILTER_SIZE-1:0][COEFF_W-1:0] r_active;

   // Shadow is deliberately unreset: every entry is rewritten before it can be copied.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_shadow[i_wr_addr] <= i_wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_active <= '0;
      end else if (i_copy) begin
         r_active <= r_shadow;
      end
   end

   assign o_active = r_active;

endmodule

`default_nettype wire

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader -- collects a coefficient set into the shadow bank and commits it atomically when swap is allowed.
// Revision: 1.0
`default_nettype none

module fir_coeff_loader
   import fir_pkg::*;
#(
   parameter int FILTER_SIZE = fir_pkg::FILTER_SIZE,
   parameter int COEFF_W     = fir_pkg::COEFF_W
) (
   input  wire logic                           clk,
   input  wire logic                           reset,
   fir_coeff_loader_if.slave                   s,
   input  wire logic                           swap_allow,
   output      logic [FILTER_SIZE*COEFF_W-1:0] fir_coeff,
   output      logic                           coeff_valid,
   output      logic                           swapped,
   output      logic                           err_len
);

   localparam int               IDX_W    = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FILTER_SIZE - 1);

   fir_state_e       r_state;
   fir_state_e       w_state_nxt;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] w_idx_nxt;
   logic [IDX_W-1:0] w_wr_addr;
   logic             w_ready;
   logic             w_wr_en;
   logic             w_commit;
   logic             w_err;
   logic             r_coeff_valid;
   logic             r_swapped;
   logic             r_err_len;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= IDLE;
         r_idx         <= '0;
         r_coeff_valid <= 1'b0;
         r_swapped     <= 1'b0;
         r_err_len     <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_idx         <= w_idx_nxt;
         r_coeff_valid <= r_coeff_valid | w_commit;
         r_swapped     <= w_commit;
         r_err_len     <= w_err;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_wr_addr   = r_idx;
      w_ready     = 1'b1;
      w_wr_en     = 1'b0;
      w_commit    = 1'b0;
      w_err       = 1'b0;
      case (r_state)
         IDLE, LOAD: begin
            // A set always starts at tap 0, whatever idx was left at.
            if (r_state == IDLE) begin
               w_wr_addr = '0;
            end
            if (s.s_valid) begin
               w_wr_en = 1'b1;
               if (w_wr_addr == LAST_IDX) begin
                  w_state_nxt = s.s_last ? PENDING : DRAIN;
               end else if (s.s_last) begin
                  w_err       = 1'b1;
                  w_state_nxt = IDLE;
                  w_idx_nxt   = '0;
               end else begin
                  w_state_nxt = LOAD;
                  w_idx_nxt   = w_wr_addr + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (s.s_valid && s.s_last) begin
               w_err       = 1'b1;
               w_state_nxt = IDLE;
               w_idx_nxt   = '0;
            end
         end
         PENDING: begin
            w_ready = 1'b0;
            if (swap_allow) begin
               w_commit    = 1'b1;
               w_state_nxt = IDLE;
               w_idx_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
         end
      endcase
   end

   fir_coeff_bank #(
      .FILTER_SIZE (FILTER_SIZE),
      .COEFF_W     (COEFF_W),
      .IDX_W       (IDX_W)
   ) u_bank (
      .clk       (clk),
      .reset     (reset),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (w_wr_addr),
      .i_wr_data (s.s_data),
      .i_copy    (w_commit),
      .o_active  (fir_coeff)
   );

   assign s.s_ready   = w_ready;
   assign coeff_valid = r_coeff_valid;
   assign swapped     = r_swapped;
   assign err_len     = r_err_len;

endmodule

`default_nettype wire

// File: tb/tb_fir_coeff_loader.sv
// tb_fir_coeff_loader -- randomized scenario bench with a set-level reference model for fir_coeff_loader.
// Revision: 1.0
`default_nettype none

module tb_fir_coeff_loader;

   localparam int FS = 8;
   localparam int CW = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             swap_allow;
   logic [FS*CW-1:0] fir_coeff;
   logic             coeff_valid;
   logic             swapped;
   logic             err_len;

   int checks   = 0;
   int errors   = 0;
   int swap_cnt = 0;
   int err_cnt  = 0;
   int both_cnt = 0;

   logic [FS*CW-1:0] swap_log[$];
   logic [CW-1:0]    set_data[32];
   logic [FS*CW-1:0] exp_active;
   logic             exp_valid;

   fir_coeff_loader_if #(.COEFF_W(CW)) bus();

   fir_coeff_loader #(
      .FILTER_SIZE (FS),
      .COEFF_W     (CW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .s           (bus.slave),
      .swap_allow  (swap_allow),
      .fir_coeff   (fir_coeff),
      .coeff_valid (coeff_valid),
      .swapped     (swapped),
      .err_len     (err_len)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset) begin
         if (swapped) begin
            swap_cnt = swap_cnt + 1;
            swap_log.push_back(fir_coeff);
         end
         if (err_len) err_cnt = err_cnt + 1;
         if (swapped && err_len) both_cnt = both_cnt + 1;
      end
   end

   // Reference: a committed bank is simply the first FS words of a set, tap k in slice k.
   function automatic logic [FS*CW-1:0] pack_set(input int off);
      logic [FS*CW-1:0] v;
      v = '0;
      for (int k = 0; k < FS; k++) v[k*CW +: CW] = set_data[off + k];
      return v;
   endfunction

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_beats(input int n, input bit with_last, input bit keep_valid, input int off);
      int guard;
      for (int i = 0; i < n; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = set_data[off + i];
         bus.s_last  = with_last && (i == n - 1);
         guard = 0;
         @(negedge clk);
         while (!bus.s_ready && guard < 200) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 200) begin
            checks++; errors++;
            $display("FAIL beat_timeout beat %0d: s_ready stayed 0, required 1", i);
         end
         @(posedge clk);
         #1;
      end
      if (!keep_valid) begin
         bus.s_valid = 1'b0;
         bus.s_last  = 1'b0;
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks++; if (fir_coeff !== '0) begin errors++; $display("FAIL reset_coeff got %h required 0", fir_coeff); end
      checks++; if (coeff_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b required 0", coeff_valid); end
      checks++; if (swapped !== 1'b0 || err_len !== 1'b0) begin errors++; $display("FAIL reset_pulses got swapped=%b err_len=%b required 0/0", swapped, err_len); end
      checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b required 1", bus.s_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_full_set;
      int sw0;
      sw0 = swap_cnt;
      for (int k = 0; k < FS; k++) set_data[k] = CW'((k + 1) * 16'h0100);
      swap_allow = 1'b1;
      send_beats(FS, 1'b1, 1'b0, 0);
      wait_cycles(4);
      exp_active = pack_set(0);
      exp_valid  = 1'b1;
      checks++; if (swap_cnt - sw0 != 1) begin errors++; $display("FAIL full_swapped_count got %0d required 1", swap_cnt - sw0); end
      checks++; if (coeff_valid !== 1'b1) begin errors++; $display("FAIL full_valid got %b required 1", coeff_valid); end
      for (int k = 0; k < FS; k++) begin
         logic [CW-1:0] want;
         want = CW'((k + 1) * 16'h0100);
         checks++;
         if (fir_coeff[k*CW +: CW] !== want) begin
            errors++; $display("FAIL full_tap%0d got %h required %h", k, fir_coeff[k*CW +: CW], want);
         end
      end
   endtask

   task automatic test_short_set;
      int sw0, er0;
      sw0 = swap_cnt; er0 = err_cnt;
      for (int k = 0; k < 5; k++) set_data[k] = CW'($urandom);
      send_beats(5, 1'b1, 1'b0, 0);
      checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL short_err_timing got %b required 1", err_len); end
      wait_cycles(4);
      checks++; if (err_cnt - er0 != 1) begin errors++; $display("FAIL short_err_count got %0d required 1", err_cnt - er0); end
      checks++; if (swap_cnt != sw0) begin errors++; $display("FAIL short_no_swap got %0d required 0", swap_cnt - sw0); end
      checks++; if (fir_coeff !== exp_active) begin errors++; $display("FAIL short_coeff got %h required %h", fir_coeff, exp_active); end
      checks++; if (coeff_valid !== exp_valid) begin errors++; $display("FAIL short_valid got %b required %b", coeff_valid, exp_valid); end
   endtask

   task automatic test_long_set;
      int sw0, er0;
      sw0 = swap_cnt; er0 = err_cnt;
      for (int k = 0; k < 10; k++) set_data[k] = CW'($urandom);
      send_beats(9, 1'b0, 1'b1, 0);
      checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL long_early_err got %b required 0", err_len); end
      send_beats(1, 1'b1, 1'b0, 9);
      checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL long_err_timing got %b required 1", err_len); end
      wait_cycles(4);
      checks++; if (err_cnt - er0 != 1) begin errors++; $display("FAIL long_err_count got %0d required 1", err_cnt - er0); end
      checks++; if (swap_cnt != sw0) begin errors++; $display("FAIL long_no_swap got %0d required 0", swap_cnt - sw0); end
      checks++; if (fir_coeff !== exp_active) begin errors++; $display("FAIL long_coeff got %h required %h", fir_coeff, exp_active); end
   endtask

   task automatic test_swap_hold;
      int bad_ready, bad_coeff;
      logic [FS*CW-1:0] new_set;
      bad_ready = 0; bad_coeff = 0;
      for (int k = 0; k < FS; k++) set_data[k] = CW'($urandom);
      new_set = pack_set(0);
      swap_allow = 1'b0;
      send_beats(FS, 1'b1, 1'b0, 0);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.s_ready !== 1'b0) bad_ready++;
         if (fir_coeff !== exp_active || swapped !== 1'b0) bad_coeff++;
         @(posedge clk); #1;
      end
      checks++; if (bad_ready != 0) begin errors++; $display("FAIL hold_ready got %0d cycles with s_ready!=0 required 0", bad_ready); end
      checks++; if (bad_coeff != 0) begin errors++; $display("FAIL hold_coeff got %0d cycles changed required 0", bad_coeff); end
      swap_allow = 1'b1;
      @(posedge clk);
      @(negedge clk);
      exp_active = new_set;
      exp_valid  = 1'b1;
      checks++; if (swapped !== 1'b1) begin errors++; $display("FAIL hold_commit_pulse got %b required 1", swapped); end
      checks++; if (fir_coeff !== exp_active) begin errors++; $display("FAIL hold_commit_coeff got %h required %h", fir_coeff, exp_active); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midset;
      int sw0;
      for (int k = 0; k < FS; k++) set_data[k] = CW'($urandom);
      send_beats(4, 1'b0, 1'b0, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_active = '0;
      exp_valid  = 1'b0;
      @(negedge clk);
      checks++; if (fir_coeff !== exp_active) begin errors++; $display("FAIL midrst_coeff got %h required 0", fir_coeff); end
      checks++; if (coeff_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b required 0", coeff_valid); end
      checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b required 1", bus.s_ready); end
      @(posedge clk); #1;
      sw0 = swap_cnt;
      for (int k = 0; k < FS; k++) set_data[k] = CW'($urandom);
      send_beats(FS, 1'b1, 1'b0, 0);
      wait_cycles(4);
      exp_active = pack_set(0);
      exp_valid  = 1'b1;
      checks++; if (swap_cnt - sw0 != 1) begin errors++; $display("FAIL midrst_resend_swap got %0d required 1", swap_cnt - sw0); end
      checks++; if (fir_coeff !== exp_active) begin errors++; $display("FAIL midrst_resend_coeff got %h required %h", fir_coeff, exp_active); end
   endtask

   task automatic test_back_to_back;
      logic [FS*CW-1:0] set_a, set_b;
      swap_log.delete();
      for (int k = 0; k < 2*FS; k++) set_data[k] = CW'($urandom);
      set_a = pack_set(0);
      set_b = pack_set(FS);
      swap_allow = 1'b1;
      send_beats(FS, 1'b1, 1'b1, 0);
      send_beats(FS, 1'b1, 1'b0, FS);
      wait_cycles(4);
      exp_active = set_b;
      checks++;
      if (swap_log.size() != 2) begin
         errors++; $display("FAIL b2b_swap_count got %0d required 2", swap_log.size());
      end else begin
         checks++; if (swap_log[0] !== set_a) begin errors++; $display("FAIL b2b_first_set got %h required %h", swap_log[0], set_a); end
         checks++; if (swap_log[1] !== set_b) begin errors++; $display("FAIL b2b_second_set got %h required %h", swap_log[1], set_b); end
      end
      checks++; if (fir_coeff !== exp_active) begin errors++; $display("FAIL b2b_final got %h required %h", fir_coeff, exp_active); end
   endtask

   task automatic test_random;
      int n, sw0, er0;
      bit good;
      for (int it = 0; it < 10; it++) begin
         n = ($urandom_range(0, 1) == 0) ? FS : int'($urandom_range(2, 13));
         good = (n == FS);
         for (int k = 0; k < n; k++) set_data[k] = CW'($urandom);
         sw0 = swap_cnt; er0 = err_cnt;
         swap_allow = 1'b0;
         fork
            send_beats(n, 1'b1, 1'b0, 0);
            begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               #2 swap_allow = 1'b1;
            end
         join
         swap_allow = 1'b1;
         wait_cycles(6);
         if (good) begin
            exp_active = pack_set(0);
            exp_valid  = 1'b1;
         end
         checks++; if (swap_cnt - sw0 != int'(good)) begin errors++; $display("FAIL rand%0d_swaps n=%0d got %0d required %0d", it, n, swap_cnt - sw0, int'(good)); end
         checks++; if (err_cnt - er0 != int'(!good)) begin errors++; $display("FAIL rand%0d_errs n=%0d got %0d required %0d", it, n, err_cnt - er0, int'(!good)); end
         checks++; if (fir_coeff !== exp_active) begin errors++; $display("FAIL rand%0d_coeff n=%0d got %h required %h", it, n, fir_coeff, exp_active); end
         checks++; if (coeff_valid !== exp_valid) begin errors++; $display("FAIL rand%0d_valid got %b required %b", it, coeff_valid, exp_valid); end
      end
   endtask

   task automatic test_exclusive;
      checks++; if (both_cnt != 0) begin errors++; $display("FAIL pulse_overlap got %0d cycles required 0", both_cnt); end
   endtask

   initial begin
      reset       = 1'b1;
      swap_allow  = 1'b1;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
      exp_active  = '0;
      exp_valid   = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      test_reset();
      test_full_set();
      test_short_set();
      test_long_set();
      test_swap_hold();
      test_reset_midset();
      test_back_to_back();
      test_random();
      test_exclusive();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not complete, required completion");
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/fir_coeff_loader.md
FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

Interface
REQ-001 Parameter: FILTER_SIZE, default 204, number of taps.
REQ-002 Parameter: COEFF_W, default 16, coefficient width, signed Q1.15.
REQ-003 The block SHALL use clk (input, 1), rising-edge clock for all state.
REQ-004 The block SHALL use reset (input, 1), synchronous, active-high; clock clk.
REQ-005 The block SHALL have port s_valid (input, 1): a coefficient beat is offered.
REQ-006 The block SHALL have port s_ready (output, 1): the block accepts the offered beat.
REQ-007 The block SHALL have port s_data (input, COEFF_W): coefficient value; beat k is tap k.
REQ-008 The block SHALL have port s_last (input, 1): marks the final beat of a set.
REQ-009 The block SHALL have port swap_allow (input, 1): the filter is between samples, so an active-bank update is safe.
REQ-010 The block SHALL have port fir_coeff (output, FILTER_SIZE*COEFF_W): active bank, tap k at bits [k*COEFF_W +: COEFF_W].
REQ-011 The block SHALL have port coeff_valid (output, 1): high once any complete set has been committed.
REQ-012 The block SHALL have port swapped (output, 1): one-cycle pulse on each commit.
REQ-013 The block SHALL have port err_len (output, 1): one-cycle pulse when a set is rejected for wrong length.

Function
REQ-014 The block SHALL hold a shadow bank and an active bank, each FILTER_SIZE x COEFF_W; fir_coeff is driven only from the active bank.
REQ-015 The FSM SHALL have states IDLE, LOAD, DRAIN and PENDING.
REQ-016 A beat is accepted on a cycle with s_valid and s_ready both high; s_ready SHALL be high in IDLE, LOAD and DRAIN, and low in PENDING.
REQ-017 An accepted beat in IDLE or LOAD SHALL write s_data to shadow[idx] and increment idx; IDLE clears idx to 0 and moves to LOAD on the first accepted beat.
REQ-018 An accepted beat with idx==FILTER_SIZE-1 and s_last=1 SHALL move the FSM to PENDING.
REQ-019 An accepted beat with s_last=1 and idx<FILTER_SIZE-1 (short set) SHALL pulse err_len on the next cycle, return to IDLE, and leave the active bank unchanged.
REQ-020 An accepted beat with idx==FILTER_SIZE-1 and s_last=0 (long set) SHALL move the FSM to DRAIN.
REQ-021 In DRAIN, beats SHALL be discarded until a beat with s_last=1 is accepted; the block then pulses err_len and returns to IDLE with the active bank unchanged.
REQ-022 In PENDING, on the first cycle with swap_allow=1, all FILTER_SIZE active entries SHALL copy the shadow bank in that single clock edge; swapped pulses and coeff_valid sets on the following cycle, and the FSM returns to IDLE.
REQ-023 If swap_allow is high on the cycle PENDING is entered, the earliest commit is the next edge; a commit is never partial, and fir_coeff never mixes two sets.
REQ-024 swapped and err_len SHALL never assert in the same cycle.
REQ-025 idx SHALL be $clog2(FILTER_SIZE) bits wide and SHALL never wrap; the overflow condition is handled only via DRAIN.

Reset
REQ-026 Reset SHALL set the FSM to IDLE, idx to 0, every active entry to 0 (so fir_coeff is all zeros), and coeff_valid, swapped and err_len to 0.
REQ-027 The shadow bank is not reset; its contents are don't-care until fully rewritten.
REQ-028 Reset during LOAD, DRAIN or PENDING SHALL abandon the set; no commit occurs, and s_ready is high on the first cycle after reset deasserts.

Structure
REQ-029 Package fir_pkg SHALL hold FILTER_SIZE, COEFF_W and the FSM state enum, shared with the direct-form filters and the coefficient broadcaster.
REQ-030 The active/shadow register pair with write port and parallel copy SHALL be one sub-module, fir_coeff_bank; the FSM and handshake stay in fir_coeff_loader.

Verification (bench FILTER_SIZE=8)
REQ-031 Send 8 beats 0x0100..0x0800 with last on beat 8 and swap_allow=1 -> swapped pulses once, coeff_valid=1, tap k = 0x0100*(k+1).
REQ-032 Send 5 beats with last on beat 5 -> err_len pulse, fir_coeff unchanged, coeff_valid unchanged.
REQ-033 Send 10 beats with last on beat 10 -> beats 9-10 discarded, err_len pulse after beat 10, no commit.
REQ-034 Send a full set while holding swap_allow=0 for 20 cycles -> s_ready=0 and fir_coeff is the old set throughout; commit occurs the edge after swap_allow rises.
REQ-035 Assert reset after 4 beats of a set -> fir_coeff all zeros, coeff_valid=0, s_ready=1 next cycle; a following full set commits correctly.
REQ-036 Send back-to-back sets with s_valid held high -> each set commits intact, with no beat lost or misassigned across the PENDING stall.
